// File: rtl/vxe_vpu_cmd_dispatch.sv
// Command dispatcher for the VxE vector processing unit.
// Pops the command queue head, forwards configuration writes to the thread
// units, maintains the thread enable mask, and sequences execute commands.
// While an execute command runs, nothing new is popped.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting commands; o_rd follows i_vld
// S_START | one-cycle start pulse to the frozen run mask
// S_WAIT  | waiting for every thread in the run mask to drop busy
module vxe_vpu_cmd_dispatch #(
    parameter int NTHR = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_vld,
    output logic            o_rd,
    input  logic [4:0]      i_op,
    input  logic [2:0]      i_th,
    input  logic [47:0]     i_pl,
    output logic            o_cfg_we,
    output logic [2:0]      o_cfg_th,
    output logic [2:0]      o_cfg_reg,
    output logic [47:0]     o_cfg_data,
    output logic [NTHR-1:0] o_thr_start,
    output logic            o_thr_op,
    input  logic [NTHR-1:0] i_thr_busy,
    output logic [NTHR-1:0] o_en_mask,
    output logic            o_busy,
    output logic            o_err,
    input  logic            i_err_clr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_SETEN = 5'h0D;
    localparam logic [4:0] OP_PROD  = 5'h10;
    localparam logic [4:0] OP_STORE = 5'h11;

    logic [1:0]      state_q, state_d;
    logic [NTHR-1:0] run_mask_q, run_mask_d;
    logic            kind_q, kind_d;
    logic [NTHR-1:0] en_mask_q, en_mask_d;
    logic            cfg_we_q, cfg_we_d;
    logic [2:0]      cfg_th_q, cfg_th_d;
    logic [2:0]      cfg_reg_q, cfg_reg_d;
    logic [47:0]     cfg_data_q, cfg_data_d;
    logic            err_q, err_d;

    logic pop;
    logic is_set, is_en, is_exec, is_known;

    // Opcode decode of the queue head; pop depends only on state and i_vld
    always_comb begin
        pop      = (state_q == S_IDLE) && i_vld;
        is_set   = (i_op >= 5'h08) && (i_op <= 5'h0C);
        is_en    = (i_op == OP_SETEN);
        is_exec  = (i_op == OP_PROD) || (i_op == OP_STORE);
        is_known = (i_op == OP_NOP) || is_set || is_en || is_exec;
    end

    // Sequencer next state; an execute with an empty enable mask is dropped
    always_comb begin
        state_d    = state_q;
        run_mask_d = run_mask_q;
        kind_d     = kind_q;
        case (state_q)
            S_IDLE: begin
                if (pop && is_exec && (en_mask_q != '0)) begin
                    run_mask_d = en_mask_q;
                    kind_d     = i_op[0];
                    state_d    = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if ((i_thr_busy & run_mask_q) == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Config write, enable mask and sticky error next-state (error set wins)
    always_comb begin
        cfg_we_d   = pop && is_set;
        cfg_th_d   = cfg_th_q;
        cfg_reg_d  = cfg_reg_q;
        cfg_data_d = cfg_data_q;
        if (pop && is_set) begin
            cfg_th_d   = i_th;
            cfg_reg_d  = i_op[2:0];
            cfg_data_d = i_pl;
        end
        en_mask_d = en_mask_q;
        if (pop && is_en) begin
            for (int i = 0; i < NTHR; i++) begin
                if (i_th == 3'(i)) en_mask_d[i] = i_pl[0];
            end
        end
        err_d = err_q;
        if (pop && !is_known) err_d = 1'b1;
        else if (i_err_clr)   err_d = 1'b0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            run_mask_q <= '0;
            kind_q     <= 1'b0;
            en_mask_q  <= '0;
            cfg_we_q   <= 1'b0;
            cfg_th_q   <= '0;
            cfg_reg_q  <= '0;
            cfg_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_mask_q <= run_mask_d;
            kind_q     <= kind_d;
            en_mask_q  <= en_mask_d;
            cfg_we_q   <= cfg_we_d;
            cfg_th_q   <= cfg_th_d;
            cfg_reg_q  <= cfg_reg_d;
            cfg_data_q <= cfg_data_d;
            err_q      <= err_d;
        end
    end

    // Output mapping
    always_comb begin
        o_rd        = pop;
        o_cfg_we    = cfg_we_q;
        o_cfg_th    = cfg_th_q;
        o_cfg_reg   = cfg_reg_q;
        o_cfg_data  = cfg_data_q;
        o_thr_start = (state_q == S_START) ? run_mask_q : '0;
        o_thr_op    = kind_q;
        o_en_mask   = en_mask_q;
        o_busy      = (state_q != S_IDLE);
        o_err       = err_q;
    end

endmodule

// File: tb/tb_vxe_vpu_cmd_dispatch.sv
// Bench for vxe_vpu_cmd_dispatch: a command queue feeder, a thread busy
// model, and a per-command reference model of the dispatcher rules.
module tb_vxe_vpu_cmd_dispatch;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_vld;
    logic        o_rd;
    logic [4:0]  i_op;
    logic [2:0]  i_th;
    logic [47:0] i_pl;
    logic        o_cfg_we;
    logic [2:0]  o_cfg_th;
    logic [2:0]  o_cfg_reg;
    logic [47:0] o_cfg_data;
    logic [7:0]  o_thr_start;
    logic        o_thr_op;
    logic [7:0]  i_thr_busy;
    logic [7:0]  o_en_mask;
    logic        o_busy;
    logic        o_err;
    logic        i_err_clr;

    always #5 clk = ~clk;

    vxe_vpu_cmd_dispatch #(.NTHR(8)) dut (
        .clk(clk), .nrst(nrst), .i_vld(i_vld), .o_rd(o_rd),
        .i_op(i_op), .i_th(i_th), .i_pl(i_pl),
        .o_cfg_we(o_cfg_we), .o_cfg_th(o_cfg_th), .o_cfg_reg(o_cfg_reg),
        .o_cfg_data(o_cfg_data), .o_thr_start(o_thr_start), .o_thr_op(o_thr_op),
        .i_thr_busy(i_thr_busy), .o_en_mask(o_en_mask), .o_busy(o_busy),
        .o_err(o_err), .i_err_clr(i_err_clr)
    );

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  th;
        logic [47:0] pl;
    } cmd_t;

    cmd_t cmdq[$];
    logic feed_en;

    // reference model: run phase 0 = idle, 1 = start cycle, 2 = waiting
    int          phase;
    logic [7:0]  m_mask, m_run;
    logic        m_kind, m_err;
    logic        e_we;
    logic [2:0]  e_th, e_reg;
    logic [47:0] e_data;

    // thread model
    int          cnt [8];
    logic [7:0]  extra_busy;
    int          blen_min, blen_max;

    int n_pass, n_tot;
    int n_we, n_start;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tot++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    endtask

    task automatic push(input logic [4:0] op, input logic [2:0] th, input logic [47:0] pl);
        cmd_t c;
        c.op = op; c.th = th; c.pl = pl;
        cmdq.push_back(c);
    endtask

    task automatic drive_head();
        if (feed_en && cmdq.size() > 0) begin
            i_vld = 1'b1;
            i_op  = cmdq[0].op;
            i_th  = cmdq[0].th;
            i_pl  = cmdq[0].pl;
        end else begin
            i_vld = 1'b0;
            i_op  = 5'($urandom);
            i_th  = 3'($urandom);
            i_pl  = {16'($urandom), 32'($urandom)};
        end
    endtask

    task automatic drive_busy();
        for (int i = 0; i < 8; i++) i_thr_busy[i] = (cnt[i] > 0) || extra_busy[i];
    endtask

    task automatic model_reset();
        phase = 0; m_mask = '0; m_run = '0; m_kind = 1'b0; m_err = 1'b0; e_we = 1'b0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
    endtask

    // One clock: compare outputs against the model at negedge, advance the
    // model with the inputs it saw, then update queue/threads after posedge.
    task automatic step();
        logic        pop_s, ex_pop;
        logic [7:0]  start_s;
        @(negedge clk);
        chk("o_rd", o_rd, (phase == 0) && i_vld);
        chk("o_busy", o_busy, phase != 0);
        chk("o_cfg_we", o_cfg_we, e_we);
        if (e_we) begin
            chk("o_cfg_th", o_cfg_th, e_th);
            chk("o_cfg_reg", o_cfg_reg, e_reg);
            chk("o_cfg_data", o_cfg_data, e_data);
        end
        chk("o_thr_start", o_thr_start, (phase == 1) ? m_run : 8'h00);
        if (phase == 1) chk("o_thr_op", o_thr_op, m_kind);
        chk("o_en_mask", o_en_mask, m_mask);
        chk("o_err", o_err, m_err);
        n_we    += int'(o_cfg_we);
        n_start += int'(o_thr_start != 0);
        pop_s   = o_rd;
        start_s = o_thr_start;

        ex_pop = (phase == 0) && i_vld && nrst;
        e_we   = 1'b0;
        if (phase == 1) phase = 2;
        else if (phase == 2 && (i_thr_busy & m_run) == 8'h00) phase = 0;
        if (ex_pop) begin
            case (i_op)
                5'h00: ;
                5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C: begin
                    e_we = 1'b1; e_th = i_th; e_reg = 3'(i_op - 5'h08); e_data = i_pl;
                end
                5'h0D: m_mask[i_th] = i_pl[0];
                5'h10, 5'h11: begin
                    if (m_mask != 8'h00) begin
                        m_run = m_mask; m_kind = (i_op == 5'h11); phase = 1;
                    end
                end
                default: m_err = 1'b1;
            endcase
        end
        if (nrst && i_err_clr && !(ex_pop && m_err && !(i_op inside {5'h00, [5'h08:5'h0D], 5'h10, 5'h11})))
            m_err = 1'b0;

        @(posedge clk);
        #1;
        if (pop_s && cmdq.size() > 0) void'(cmdq.pop_front());
        for (int i = 0; i < 8; i++) begin
            if (start_s[i]) cnt[i] = $urandom_range(blen_max, blen_min);
            else if (cnt[i] > 0) cnt[i]--;
        end
        drive_busy();
        drive_head();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int k;
        k = 0;
        while ((cmdq.size() > 0 || o_busy || phase != 0) && k < max_cyc) begin
            step();
            k++;
        end
        if (k >= max_cyc) chk("timeout", 1, 0);
        step();
    endtask

    int we0, st0, pushed;

    initial begin
        n_pass = 0; n_tot = 0; n_we = 0; n_start = 0;
        nrst = 1'b0; i_err_clr = 1'b0; feed_en = 1'b1; extra_busy = '0;
        blen_min = 1; blen_max = 6;
        model_reset();
        drive_busy();
        drive_head();

        // reset and idle
        repeat (2) step();
        chk("rst_cfg_th", o_cfg_th, 0);
        chk("rst_cfg_reg", o_cfg_reg, 0);
        chk("rst_cfg_data", o_cfg_data, 0);
        chk("rst_thr_op", o_thr_op, 0);
        nrst = 1'b1;
        repeat (3) step();
        chk("idle_rd", o_rd, 0);

        // back-to-back config writes
        we0 = n_we;
        push(5'h09, 3'd3, 48'h400);
        push(5'h0A, 3'd3, 48'h1000);
        drive_head();
        run_until_idle(20);
        chk("cfg_count", n_we - we0, 2);

        // enable threads 0 and 2, execute PROD with 5-cycle busy
        blen_min = 5; blen_max = 5;
        st0 = n_start;
        push(5'h0D, 3'd0, 48'h1);
        push(5'h0D, 3'd2, 48'h1);
        push(5'h10, 3'd0, 48'h0);
        push(5'h08, 3'd1, 48'hABCD);
        drive_head();
        run_until_idle(40);
        chk("en_mask_05", o_en_mask, 8'h05);
        chk("prod_starts", n_start - st0, 1);

        // PROD with empty mask is dropped; unknown opcode and error clear
        st0 = n_start;
        push(5'h0D, 3'd0, 48'h0);
        push(5'h0D, 3'd2, 48'h0);
        push(5'h10, 3'd0, 48'h0);
        push(5'h1F, 3'd0, 48'h0);
        drive_head();
        run_until_idle(20);
        chk("empty_prod_starts", n_start - st0, 0);
        chk("err_set", o_err, 1);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        step();
        chk("err_clr", o_err, 0);
        push(5'h1E, 3'd0, 48'h0);
        drive_head();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        chk("err_set_wins", o_err, 1);
        run_until_idle(10);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;

        // STORE on thread 0 while unrelated thread 5 stays busy
        blen_min = 3; blen_max = 3;
        st0 = n_start;
        extra_busy = 8'h20;
        drive_busy();
        push(5'h0D, 3'd0, 48'h1);
        push(5'h11, 3'd0, 48'h0);
        drive_head();
        run_until_idle(30);
        chk("store_starts", n_start - st0, 1);
        chk("store_op", o_thr_op, 1);
        extra_busy = 8'h00;
        drive_busy();

        // reset during WAIT, then a normal run
        blen_min = 20; blen_max = 20;
        push(5'h0D, 3'd1, 48'h1);
        push(5'h10, 3'd0, 48'h0);
        drive_head();
        for (int k = 0; k < 20 && phase != 2; k++) step();
        chk("reached_wait", phase, 2);
        repeat (3) step();
        nrst = 1'b0;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_mask", o_en_mask, 0);
        chk("rst_start", o_thr_start, 0);
        cmdq.delete();
        model_reset();
        drive_busy();
        drive_head();
        repeat (2) step();
        nrst = 1'b1;
        blen_min = 2; blen_max = 4;
        st0 = n_start;
        push(5'h0D, 3'd6, 48'h1);
        push(5'h10, 3'd0, 48'h0);
        drive_head();
        run_until_idle(30);
        chk("post_rst_starts", n_start - st0, 1);
        chk("post_rst_mask", o_en_mask, 8'h40);

        // randomized traffic
        blen_min = 1; blen_max = 6;
        pushed = 0;
        while (pushed < 300) begin
            if (cmdq.size() < 4) begin
                int r;
                logic [4:0] op;
                r = $urandom_range(0, 15);
                case (r)
                    0:       op = 5'h00;
                    1, 2:    op = 5'h08 + 5'($urandom_range(0, 4));
                    3, 4:    op = 5'h0D;
                    5, 6, 7: op = 5'h0D;
                    8, 9:    op = 5'h10;
                    10, 11:  op = 5'h11;
                    12:      op = 5'h0E + 5'($urandom_range(0, 1));
                    13:      op = 5'h12 + 5'($urandom_range(0, 13));
                    default: op = 5'h08 + 5'($urandom_range(0, 4));
                endcase
                push(op, 3'($urandom), {16'($urandom), 32'($urandom)});
                pushed++;
            end
            feed_en    = ($urandom_range(0, 4) != 0);
            i_err_clr  = ($urandom_range(0, 9) == 0);
            extra_busy = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            drive_busy();
            drive_head();
            step();
        end
        feed_en = 1'b1; i_err_clr = 1'b0; extra_busy = 8'h00;
        drive_busy();
        drive_head();
        run_until_idle(5000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
